// File: rtl/spi_ss_ctrl_multi.sv
// spi_ss_ctrl_multi: SPI master slave-select and frame-timing controller with queued start, gap and continuous mode
//   PCLK, PRESETn      : clock, asynchronous active-low reset
//   mstr, spiswai      : enable qualifiers (block runs when mstr=1, spiswai=0)
//   spi_mode           : 00/01 operating, 10/11 disabled
//   send_data, ss_sel  : one-cycle start request and target slave index
//   frame_len          : bits per frame, clamped to 4..16
//   baud_rate_divisor  : SCK half-period in PCLK cycles (0 treated as 1)
//   gap_cycles         : SS-high cycles between non-continuous frames
//   cont_mode          : keep SS low across back-to-back frames to the same slave
//   ss_n               : active-low slave selects
//   tip, busy          : transfer in progress, controller busy
//   receive_data       : one-cycle frame-complete strobe
//   sel_err            : one-cycle strobe for a request with ss_sel >= NUM_SS
module spi_ss_ctrl_multi #(
  parameter int NUM_SS = 4,
  parameter int SEL_W  = 2,
  parameter int BRD_W  = 12,
  parameter int GAP_W  = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              mstr,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic              send_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [4:0]        frame_len,
  input  logic [BRD_W-1:0]  baud_rate_divisor,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              cont_mode,
  output logic [NUM_SS-1:0] ss_n,
  output logic              tip,
  output logic              busy,
  output logic              receive_data,
  output logic              sel_err
);
  localparam int CW = BRD_W + 6;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, tgt, tgt_n;
  logic [GAP_W-1:0] gcount, gcount_n, gap, gap_n;
  logic [SEL_W-1:0] cur_sel, cur_sel_n, pend_sel, pend_sel_n, nxt_sel;
  logic pending, pending_n, cont, cont_n, rd_n, err_n;
  logic en, req, bad, good, fin, gfin, start;
  logic [NUM_SS-1:0] ss_n_n;
  logic [4:0] l_eff;
  logic [BRD_W-1:0] d_eff;
  always_comb begin
    en = mstr & ~spiswai & ~spi_mode[1];
    l_eff = frame_len < 5'd4 ? 5'd4 : frame_len > 5'd16 ? 5'd16 : frame_len;
    d_eff = baud_rate_divisor == '0 ? BRD_W'(1) : baud_rate_divisor;
    req = en & send_data;
    bad = req & (32'(ss_sel) >= NUM_SS);
    good = req & ~bad;
    fin = state == ACTIVE && count == tgt - 1'b1;
    gfin = state == GAP && gcount == gap - 1'b1;
    // A queued request takes priority over a fresh one arriving on the same edge
    nxt_sel = pending ? pend_sel : ss_sel;
    start = (state == IDLE && (pending || good)) || (gfin && pending) ||
            (fin && (pending || good) && cont && nxt_sel == cur_sel);
    state_n = !en ? IDLE : start ? ACTIVE : fin ? (gap != '0 ? GAP : IDLE) : gfin ? IDLE : state;
    count_n = state_n == ACTIVE && !start ? count + 1'b1 : '0;
    gcount_n = state_n == GAP && state == GAP ? gcount + 1'b1 : '0;
    pending_n = en && !start && (pending || good);
    pend_sel_n = good && !pending ? ss_sel : pend_sel;
    cur_sel_n = start ? nxt_sel : cur_sel;
    tgt_n = start ? (CW'(d_eff) * CW'(l_eff)) << 1 : tgt;
    gap_n = start ? gap_cycles : gap;
    cont_n = start ? cont_mode : cont;
    ss_n_n = state_n == ACTIVE ? ~(NUM_SS'(1) << cur_sel_n) : '1;
    rd_n = en & fin;
    err_n = bad;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      count <= '0;
      gcount <= '0;
      tgt <= '0;
      gap <= '0;
      cur_sel <= '0;
      pend_sel <= '0;
      pending <= 1'b0;
      cont <= 1'b0;
      ss_n <= '1;
      receive_data <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      gcount <= gcount_n;
      tgt <= tgt_n;
      gap <= gap_n;
      cur_sel <= cur_sel_n;
      pend_sel <= pend_sel_n;
      pending <= pending_n;
      cont <= cont_n;
      ss_n <= ss_n_n;
      receive_data <= rd_n;
      sel_err <= err_n;
    end
  end
  assign tip = ~&ss_n;
  assign busy = state != IDLE || pending;
endmodule

// File: tb/tb_spi_ss_ctrl_multi.sv
// tb_spi_ss_ctrl_multi: directed self-checking bench for spi_ss_ctrl_multi
module tb_spi_ss_ctrl_multi;
  logic PCLK = 1'b0, PRESETn = 1'b0, mstr = 1'b0, spiswai = 1'b0, send_data = 1'b0, cont_mode = 1'b0;
  logic [1:0] spi_mode = 2'b00;
  logic [2:0] ss_sel = '0;
  logic [4:0] frame_len = 5'd8;
  logic [11:0] baud_rate_divisor = 12'd2;
  logic [3:0] gap_cycles = '0;
  logic [3:0] ss_n;
  logic tip, busy, receive_data, sel_err;
  int checks = 0, errors = 0, n, rc;
  spi_ss_ctrl_multi #(.NUM_SS(4), .SEL_W(3), .BRD_W(12), .GAP_W(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
    .send_data(send_data), .ss_sel(ss_sel), .frame_len(frame_len),
    .baud_rate_divisor(baud_rate_divisor), .gap_cycles(gap_cycles), .cont_mode(cont_mode),
    .ss_n(ss_n), .tip(tip), .busy(busy), .receive_data(receive_data), .sel_err(sel_err)
  );
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic pulse(input logic [2:0] s);
    send_data = 1'b1;
    ss_sel = s;
    tick();
    send_data = 1'b0;
  endtask
  task automatic meas(input logic [3:0] pat, output int cnt, output int rcnt);
    cnt = 0;
    rcnt = 0;
    while (ss_n == pat && cnt < 2000) begin
      tick();
      cnt++;
      if (receive_data) rcnt++;
    end
  endtask
  initial begin
    tick();
    check("rst_ss", ss_n, 4'hF);
    check("rst_tip", tip, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", receive_data, 0);
    check("rst_err", sel_err, 0);
    PRESETn = 1'b1;
    mstr = 1'b1;
    tick();
    pulse(1);
    check("f1_ss", ss_n, 4'b1101);
    check("f1_tip", tip, 1);
    check("f1_busy", busy, 1);
    meas(4'b1101, n, rc);
    check("f1_len", n, 32);
    check("f1_rd", receive_data, 1);
    check("f1_rcnt", rc, 1);
    check("f1_busy_end", busy, 0);
    tick();
    check("f1_rd_off", receive_data, 0);
    baud_rate_divisor = 12'd1;
    frame_len = 5'd2;
    pulse(0);
    meas(4'b1110, n, rc);
    check("clamp_lo", n, 8);
    frame_len = 5'd31;
    pulse(0);
    meas(4'b1110, n, rc);
    check("clamp_hi", n, 32);
    baud_rate_divisor = 12'd0;
    frame_len = 5'd4;
    pulse(0);
    meas(4'b1110, n, rc);
    check("brd_zero", n, 8);
    baud_rate_divisor = 12'd1;
    gap_cycles = 4'd3;
    pulse(2);
    tick();
    pulse(3);
    pulse(0);
    meas(4'b1011, n, rc);
    check("gap_f1_rest", n, 5);
    check("gap_f1_rd", receive_data, 1);
    meas(4'hF, n, rc);
    check("gap_high", n, 3);
    check("gap_f2_sel", ss_n, 4'b0111);
    meas(4'b0111, n, rc);
    check("gap_f2_len", n, 8);
    check("gap_f2_rd", rc, 1);
    check("gap_busy", busy, 1);
    repeat (3) tick();
    check("gap_idle_busy", busy, 0);
    check("gap_third_dropped", ss_n, 4'hF);
    gap_cycles = 4'd0;
    cont_mode = 1'b1;
    pulse(1);
    tick();
    pulse(1);
    meas(4'b1101, n, rc);
    check("cont_len", n, 14);
    check("cont_rcnt", rc, 2);
    pulse(1);
    tick();
    pulse(2);
    meas(4'b1101, n, rc);
    check("contd_f1", n, 6);
    check("contd_rc1", rc, 1);
    check("contd_busy_pend", busy, 1);
    meas(4'hF, n, rc);
    check("contd_high", n, 1);
    check("contd_sel", ss_n, 4'b1011);
    meas(4'b1011, n, rc);
    check("contd_f2", n, 8);
    check("contd_rc2", rc, 1);
    check("contd_busy", busy, 0);
    cont_mode = 1'b0;
    pulse(5);
    check("selerr_pulse", sel_err, 1);
    check("selerr_ss", ss_n, 4'hF);
    check("selerr_busy", busy, 0);
    tick();
    check("selerr_off", sel_err, 0);
    pulse(0);
    tick();
    pulse(0);
    spiswai = 1'b1;
    tick();
    check("abort_ss", ss_n, 4'hF);
    check("abort_rd", receive_data, 0);
    check("abort_busy", busy, 0);
    pulse(6);
    check("dis_err", sel_err, 0);
    check("dis_ss", ss_n, 4'hF);
    spiswai = 1'b0;
    tick();
    check("abort_no_pend", ss_n, 4'hF);
    pulse(2);
    meas(4'b1011, n, rc);
    check("abort_restart", n, 8);
    pulse(3);
    tick();
    spi_mode = 2'b10;
    tick();
    check("mode_ss", ss_n, 4'hF);
    check("mode_rd", receive_data, 0);
    spi_mode = 2'b01;
    pulse(3);
    meas(4'b0111, n, rc);
    check("mode01_len", n, 8);
    pulse(1);
    tick();
    PRESETn = 1'b0;
    #1;
    check("prst_ss", ss_n, 4'hF);
    check("prst_busy", busy, 0);
    PRESETn = 1'b1;
    tick();
    check("prst_ss2", ss_n, 4'hF);
    check("prst_rd", receive_data, 0);
    pulse(1);
    meas(4'b1101, n, rc);
    check("prst_restart", n, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ss_ctrl_multi.md
# spi_ss_ctrl_multi

Parametrised slave-select and transfer-timing controller for the SPI master path of the integrated processor. It drives one of `NUM_SS` active-low slave selects for a frame of programmable length (4–16 bits) timed from the baud-rate divisor. It supports a one-deep queued start request, a programmable inter-frame gap, continuous (SS-held) back-to-back frames and abort on mode loss. It issues a one-cycle `receive_data` strobe per completed frame to the shift-register/data-register logic.

## Interface
- `NUM_SS`, 4: number of slave-select lines (≥2).
- `SEL_W`, 2: width of `ss_sel`; must satisfy 2^SEL_W ≥ NUM_SS.
- `BRD_W`, 12: baud-rate divisor width.
- `GAP_W`, 4: inter-frame gap counter width.

Ports:
- `PCLK`  in  1  clock; all state changes on rising edge.
- `PRESETn`  in  1  reset: asynchronous, active-low.
- `mstr`  in  1  master mode enable.
- `spiswai`  in  1  SPI stop-in-wait; 1 disables the block.
- `spi_mode`  in  2  00/01 = operating, 10/11 = disabled.
- `send_data`  in  1  one-cycle start request.
- `ss_sel`  in  SEL_W  target slave index.
- `frame_len`  in  5  bits per frame.
- `baud_rate_divisor`  in  BRD_W  SCK half-period in PCLK cycles.
- `gap_cycles`  in  GAP_W  SS-high cycles between non-continuous frames.
- `cont_mode`  in  1  hold SS low across back-to-back frames to the same slave.
- `ss_n`  out  NUM_SS  active-low slave selects.
- `tip`  out  1  transfer in progress (= any `ss_n` low).
- `busy`  out  1  state ≠ IDLE or request pending.
- `receive_data`  out  1  one-cycle frame-complete strobe.
- `sel_err`  out  1  one-cycle strobe: request rejected for `ss_sel` ≥ NUM_SS.

## Operation
- `en` = `mstr` & !`spiswai` & (`spi_mode` ∈ {00,01}).
- Effective values:
  - L = clamp(`frame_len`, 4, 16).
  - D = max(`baud_rate_divisor`, 1).
  - target = 2·D·L, computed at BRD_W+6 bits with no overflow.
- Latching: L, D, `ss_sel`, `cont_mode` and `gap_cycles` are latched when a frame starts. Input changes mid-frame are ignored.
- States:
  - IDLE: all `ss_n` high.
  - ACTIVE: `ss_n[sel]` low, `count` runs 0..target-1.
  - GAP: all `ss_n` high, `gcount` runs 0..G-1.
- Request acceptance (`send_data`=1 while `en`):
  - `ss_sel` ≥ NUM_SS: request dropped and `sel_err` pulsed.
  - Valid request in IDLE: start frame.
  - Valid request otherwise: set `pending` (one-deep), capturing `ss_sel`. A request while already pending is dropped silently.
- Frame end, on the edge where `count` == target-1:
  - `receive_data` pulses.
  - If (pending or `send_data`) and `cont_mode` and the new sel equals the current sel: stay ACTIVE, `count`←0, SS held low, pending cleared.
  - Else if G>0: go to GAP.
  - Else: go to IDLE.
- GAP end, on the edge where `gcount` == G-1: if pending, go to ACTIVE (new frame); else go to IDLE.
- IDLE with pending set: start on the next edge.
- `en` low in any state: next edge forces IDLE, all `ss_n` high, `count`/`gcount`/`pending` cleared. No `receive_data` for the aborted frame. `send_data` is ignored while `en` is low.

## Timing
- Reset values: `ss_n` all 1, `tip` 0, `busy` 0, `receive_data` 0, `sel_err` 0, state IDLE, `count` 0, `pending` 0.
- All outputs are registered; none depend combinationally on inputs.
- Start: `send_data` sampled in IDLE at edge k → `ss_n[sel]` low from edge k. SS stays low for exactly target cycles and rises at edge k+target.
- `receive_data` is high for the single cycle after edge k+target, i.e. the same cycle SS is first high.
- Non-continuous SS-high interval between frames:
  - G>0: exactly G cycles.
  - G=0 with pending: exactly 1 cycle (through IDLE).
- Continuous mode: zero SS-high cycles between frames; `receive_data` still pulses once per frame.
- `sel_err`: high for the cycle after the rejecting edge.
- `busy`: falls on the edge that enters IDLE with no pending request.

## Test plan
- Reset, then `en`=1, D=2, L=8, `ss_sel`=1, one `send_data` pulse → `ss_n`=4'b1101 for exactly 32 cycles; `receive_data` high for 1 cycle immediately after; `busy` returns to 0.
- `frame_len`=2 and `frame_len`=31 with D=1 → SS low 8 and 32 cycles respectively (clamp); `baud_rate_divisor`=0 → behaves as D=1.
- Second request mid-frame, `cont_mode`=0, G=3 → SS high exactly 3 cycles between frames; two `receive_data` pulses. Third request while pending → dropped.
- `cont_mode`=1, same sel, request queued → SS low continuously for 2·target cycles, two strobes. Same test with a different sel → 1-cycle high gap and new line selected.
- `ss_sel`=5 with NUM_SS=4 → `sel_err` 1-cycle pulse, `ss_n` stays 4'b1111, `busy` stays 0.
- `spiswai` raised mid-frame, and separately `PRESETn` pulsed mid-frame → `ss_n` all 1 after next edge (reset: immediately), no `receive_data`, pending cleared. Restart afterwards gives a full-length frame.
